// File: rtl/ir_dram_loader.sv
// IR dispatch RAM diagnostic loader, readback and port arbiter.
// Optional feature: IR_DRAM_PARGEN_EN (odd-parity generation and check on P).
module ir_dram_loader #(
    parameter int DRAM_WIDTH     = 15,
    parameter int DRAM_ADDR_BITS = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        diag_load,
    input  logic [2:0]                  diag_func,
    input  logic [0:35]                 ebus_data,
    input  logic                        ebox_run,
    input  logic [0:DRAM_ADDR_BITS-1]   ir_dr_adr,
    input  logic [0:DRAM_WIDTH-1]       dram_dout,
    output logic [0:DRAM_ADDR_BITS-1]   dram_addr,
    output logic [0:DRAM_WIDTH-1]       dram_din,
    output logic                        dram_we,
    output logic                        own_port,
    output logic                        busy,
    output logic [0:DRAM_WIDTH-1]       rd_data,
    output logic                        rd_valid,
    output logic [0:DRAM_ADDR_BITS-1]   ld_addr,
    output logic                        err_cmd
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB_W = 3'd1,
        WR    = 3'd2,
        ARB_R = 3'd3,
        RD    = 3'd4,
        RDCAP = 3'd5
    } state_t;

    localparam logic [2:0] F_LDADR = 3'd0;
    localparam logic [2:0] F_LDAB  = 3'd1;
    localparam logic [2:0] F_LDJH  = 3'd2;
    localparam logic [2:0] F_LDJL  = 3'd3;
    localparam logic [2:0] F_WRITE = 3'd4;
    localparam logic [2:0] F_READ  = 3'd5;
    localparam logic [2:0] F_CLEAR = 3'd6;

    state_t state;
    state_t state_nxt;

    logic [0:DRAM_WIDTH-1] stage;
    logic [0:DRAM_WIDTH-1] wr_word;
    logic                  grant;
    logic                  cmd_clear;
    logic                  cmd_idle;
    logic                  cmd_busy;
    logic                  ld_inc;
    logic                  rd_par_err;
    logic                  unused_ebus;

    assign grant     = ~ebox_run;
    assign cmd_clear = diag_load && (diag_func == F_CLEAR);
    assign cmd_idle  = diag_load && (state == IDLE) && !cmd_clear;
    assign cmd_busy  = diag_load && (state != IDLE) && !cmd_clear;
    assign ld_inc    = dram_we || (state == RDCAP);

    assign unused_ebus = ^ebus_data[7:26];

`ifdef IR_DRAM_PARGEN_EN
    logic par_bit;
    logic unused_stage_p;

    // P is recomputed so the stored word always has odd parity
    assign par_bit        = ~^{stage[0:5], stage[7:14]};
    assign wr_word        = {stage[0:5], par_bit, stage[7:14]};
    assign unused_stage_p = stage[6];
    assign rd_par_err     = (state == RDCAP) && !(^dram_dout);
`else
    assign wr_word    = stage;
    assign rd_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cmd_clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_idle && diag_func == F_WRITE) begin
                        state_nxt = grant ? WR : ARB_W;
                    end else if (cmd_idle && diag_func == F_READ) begin
                        state_nxt = grant ? RD : ARB_R;
                    end
                end
                ARB_W: begin
                    if (grant) begin
                        state_nxt = WR;
                    end
                end
                // A late ebox_run rise falls back to arbitration
                WR:    state_nxt = grant ? IDLE : ARB_W;
                ARB_R: begin
                    if (grant) begin
                        state_nxt = RD;
                    end
                end
                RD:    state_nxt = grant ? RDCAP : ARB_R;
                RDCAP: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        own_port  = ((state == WR) || (state == RD)) && grant;
        dram_we   = (state == WR) && grant;
        dram_addr = own_port ? ld_addr : ir_dr_adr;
        dram_din  = dram_we ? wr_word : '0;
        busy      = (state != IDLE);
        rd_valid  = (state == RDCAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage   <= '0;
            ld_addr <= '0;
            rd_data <= '0;
            err_cmd <= 1'b0;
        end else if (cmd_clear) begin
            stage   <= '0;
            rd_data <= '0;
            err_cmd <= 1'b0;
        end else begin
            if (cmd_busy || rd_par_err) begin
                err_cmd <= 1'b1;
            end
            if (cmd_idle) begin
                unique case (diag_func)
                    F_LDADR: ld_addr     <= ebus_data[27:35];
                    F_LDAB:  stage[0:6]  <= ebus_data[0:6];
                    F_LDJH:  stage[7:10] <= ebus_data[0:3];
                    F_LDJL:  stage[11:14] <= ebus_data[0:3];
                    default: ;
                endcase
            end
            if (ld_inc) begin
                ld_addr <= ld_addr + 1'b1;
            end
            if (state == RDCAP) begin
                rd_data <= dram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ir_dram_loader.sv
// Directed self-checking bench for ir_dram_loader with a model DRAM.
module tb_ir_dram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        diag_load;
    logic [2:0]  diag_func;
    logic [0:35] ebus_data;
    logic        ebox_run;
    logic [0:8]  ir_dr_adr;
    logic [0:14] dram_dout;
    logic [0:8]  dram_addr;
    logic [0:14] dram_din;
    logic        dram_we;
    logic        own_port;
    logic        busy;
    logic [0:14] rd_data;
    logic        rd_valid;
    logic [0:8]  ld_addr;
    logic        err_cmd;

    logic        pre_we;
    logic [0:8]  pre_addr;
    logic [0:14] pre_data;
    logic [0:14] mem [0:511];

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int rv_count = 0;

`ifdef IR_DRAM_PARGEN_EN
    localparam logic [0:14] EXP_W = {7'o124, 4'hA, 4'h5};
`else
    localparam logic [0:14] EXP_W = {7'o125, 4'hA, 4'h5};
`endif

    always #5 clk = ~clk;

    ir_dram_loader dut (
        .clk       (clk),
        .reset     (reset),
        .diag_load (diag_load),
        .diag_func (diag_func),
        .ebus_data (ebus_data),
        .ebox_run  (ebox_run),
        .ir_dr_adr (ir_dr_adr),
        .dram_dout (dram_dout),
        .dram_addr (dram_addr),
        .dram_din  (dram_din),
        .dram_we   (dram_we),
        .own_port  (own_port),
        .busy      (busy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ld_addr   (ld_addr),
        .err_cmd   (err_cmd)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (dram_we) mem[dram_addr] <= dram_din;
        dram_dout <= mem[dram_addr];
    end

    always @(negedge clk) begin
        if (dram_we) we_count <= we_count + 1;
        if (rd_valid) rv_count <= rv_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] f, input logic [0:35] d);
        diag_load = 1'b1;
        diag_func = f;
        ebus_data = d;
        step();
        diag_load = 1'b0;
        diag_func = 3'd0;
        ebus_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({own_port, dram_we, busy, rd_valid, err_cmd} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {own_port, dram_we, busy, rd_valid, err_cmd});
        end
        checks++;
        if (dram_addr !== 9'd0 || dram_din !== 15'd0) begin
            errors++;
            $display("FAIL reset_port got addr %h din %h exp 0 0",
                     dram_addr, dram_din);
        end
        checks++;
        if (rd_data !== 15'd0 || ld_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset_regs got rd_data %h ld_addr %h exp 0 0",
                     rd_data, ld_addr);
        end
    endtask

    task automatic test_load_write();
        int w0;
        ir_dr_adr = 9'h0AA;
        strobe(3'd0, {27'd0, 9'o254});
        strobe(3'd1, {7'o125, 29'd0});
        strobe(3'd2, {4'hA, 32'd0});
        strobe(3'd3, {4'h5, 32'd0});
        checks++;
        if (ld_addr !== 9'o254 || own_port !== 1'b0 || dram_addr !== 9'h0AA) begin
            errors++;
            $display("FAIL ldadr got ld_addr %o own %b addr %h exp 254 0 0aa",
                     ld_addr, own_port, dram_addr);
        end
        w0 = we_count;
        strobe(3'd4, 36'd0);
        checks++;
        if (dram_we !== 1'b1 || own_port !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_cycle got we %b own %b busy %b exp 1 1 1",
                     dram_we, own_port, busy);
        end
        checks++;
        if (dram_addr !== 9'o254 || dram_din !== EXP_W) begin
            errors++;
            $display("FAIL wr_data got addr %o din %h exp 254 %h",
                     dram_addr, dram_din, EXP_W);
        end
        step();
        checks++;
        if (busy !== 1'b0 || dram_we !== 1'b0 || ld_addr !== 9'o255) begin
            errors++;
            $display("FAIL wr_done got busy %b we %b ld_addr %o exp 0 0 255",
                     busy, dram_we, ld_addr);
        end
        checks++;
        if (mem[9'o254] !== EXP_W || we_count !== w0 + 1) begin
            errors++;
            $display("FAIL wr_mem got %h writes %0d exp %h 1",
                     mem[9'o254], we_count - w0, EXP_W);
        end
    endtask

    task automatic test_readback();
        pre_we = 1'b1;
        pre_addr = 9'o254;
        pre_data = 15'h1A5A;
        step();
        pre_we = 1'b0;
        strobe(3'd0, {27'd0, 9'o254});
        strobe(3'd5, 36'd0);
        checks++;
        if (own_port !== 1'b1 || dram_we !== 1'b0 || dram_addr !== 9'o254) begin
            errors++;
            $display("FAIL rd_cycle got own %b we %b addr %o exp 1 0 254",
                     own_port, dram_we, dram_addr);
        end
        step();
        checks++;
        if (rd_valid !== 1'b1 || own_port !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid got %b own %b exp 1 0", rd_valid, own_port);
        end
        step();
        checks++;
        if (rd_data !== 15'h1A5A || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got %h valid %b exp 1a5a 0", rd_data, rd_valid);
        end
        checks++;
        if (ld_addr !== 9'o255 || busy !== 1'b0 || err_cmd !== 1'b0) begin
            errors++;
            $display("FAIL rd_done got ld_addr %o busy %b err %b exp 255 0 0",
                     ld_addr, busy, err_cmd);
        end
    endtask

    task automatic test_arbitration();
        ir_dr_adr = 9'h155;
        strobe(3'd0, {27'd0, 9'o100});
        ebox_run = 1'b1;
        strobe(3'd4, 36'd0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dram_we !== 1'b0 || own_port !== 1'b0 || dram_addr !== 9'h155) begin
                errors++;
                $display("FAIL arb_hold[%0d] got we %b own %b addr %h exp 0 0 155",
                         i, dram_we, own_port, dram_addr);
            end
            step();
        end
        ebox_run = 1'b0;
        #1;
        checks++;
        if (dram_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arb_fall got we %b busy %b exp 0 1", dram_we, busy);
        end
        step();
        checks++;
        if (dram_we !== 1'b1 || dram_addr !== 9'o100 || dram_din !== EXP_W) begin
            errors++;
            $display("FAIL arb_write got we %b addr %o din %h exp 1 100 %h",
                     dram_we, dram_addr, dram_din, EXP_W);
        end
        step();
        checks++;
        if (ld_addr !== 9'o101 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_done got ld_addr %o busy %b exp 101 0", ld_addr, busy);
        end
    endtask

    task automatic test_wrap_busy();
        int w0;
        strobe(3'd0, {27'd0, 9'd511});
        w0 = we_count;
        strobe(3'd4, 36'd0);
        strobe(3'd4, 36'd0);
        checks++;
        if (ld_addr !== 9'd0 || err_cmd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap got ld_addr %0d err %b busy %b exp 0 1 0",
                     ld_addr, err_cmd, busy);
        end
        step();
        step();
        checks++;
        if (we_count !== w0 + 1 || mem[9'd511] !== EXP_W) begin
            errors++;
            $display("FAIL wrap_writes got %0d mem %h exp 1 %h",
                     we_count - w0, mem[9'd511], EXP_W);
        end
        strobe(3'd6, 36'd0);
        checks++;
        if (err_cmd !== 1'b0 || ld_addr !== 9'd0) begin
            errors++;
            $display("FAIL clear got err %b ld_addr %0d exp 0 0", err_cmd, ld_addr);
        end
    endtask

    task automatic test_reserved();
        strobe(3'd7, 36'hF_FFFF_FFFF);
        checks++;
        if (err_cmd !== 1'b0 || busy !== 1'b0 || ld_addr !== 9'd0) begin
            errors++;
            $display("FAIL reserved got err %b busy %b ld_addr %0d exp 0 0 0",
                     err_cmd, busy, ld_addr);
        end
    endtask

    task automatic test_reset_midop();
        int r0;
        ir_dr_adr = 9'd0;
        strobe(3'd0, {27'd0, 9'd5});
        strobe(3'd5, 36'd0);
        r0 = rv_count;
        checks++;
        if (own_port !== 1'b1 || dram_addr !== 9'd5) begin
            errors++;
            $display("FAIL midop_rd got own %b addr %0d exp 1 5", own_port, dram_addr);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({own_port, dram_we, busy, rd_valid, err_cmd} !== 5'b0) begin
            errors++;
            $display("FAIL midop_flags got %b exp 00000",
                     {own_port, dram_we, busy, rd_valid, err_cmd});
        end
        checks++;
        if (dram_addr !== 9'd0 || dram_din !== 15'd0 ||
            rd_data !== 15'd0 || ld_addr !== 9'd0) begin
            errors++;
            $display("FAIL midop_regs got addr %h din %h rd %h ld %h exp 0",
                     dram_addr, dram_din, rd_data, ld_addr);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (rv_count !== r0) begin
            errors++;
            $display("FAIL midop_valid got %0d pulses exp 0", rv_count - r0);
        end
    endtask

    initial begin
        reset = 1'b1;
        diag_load = 1'b0;
        diag_func = 3'd0;
        ebus_data = '0;
        ebox_run = 1'b0;
        ir_dr_adr = 9'd0;
        pre_we = 1'b0;
        pre_addr = 9'd0;
        pre_data = 15'd0;
        step();
        test_reset();
        test_load_write();
        test_readback();
        test_arbitration();
        test_wrap_busy();
        test_reserved();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
